demux4_fifo: RTL and testbench

- 1-to-4 demultiplexer with buffering; the inverse of the datapath 4-to-1 select mux.
- Takes one 32-bit word per accepted cycle and a 2-bit destination select.
- Steers the word into one of four per-channel FIFOs.
- Each channel drains independently through its own valid/ready handshake.
- Sits between the writeback/result bus and up to four consumers, e.g. register-file write ports or a debug tap.

---
 rtl/demux4_fifo.sv | 99 +++++++++
 tb/tb_demux4_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/demux4_fifo.sv
`default_nettype none
// ============================================================================
// Module      : demux4_fifo
// Description : 1-to-4 buffered demultiplexer. Each accepted word is steered
//               by in_sel into one of four independent FIFOs. Each FIFO drains
//               through its own valid/ready handshake.
//               Optional macro DEMUX4_STALL_CNT_EN adds a saturating 16-bit
//               count of cycles where in_valid=1 and in_ready=0.
// Revision    : 1.0 - initial release
// ============================================================================
module demux4_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [1:0]               in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [4*WIDTH-1:0]       out_data,
    output logic [3:0]               out_valid,
    input  logic [3:0]               out_ready,
    output logic [4*(PTR_W+1)-1:0]   occ
`ifdef DEMUX4_STALL_CNT_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    localparam logic [PTR_W:0] c_full_cnt = (PTR_W+1)'(DEPTH);

    logic [3:0] w_full;

    // Acceptance depends only on the registered count of the selected
    // channel, so a full channel refuses a push even if it pops this cycle.
    assign in_ready = !w_full[in_sel];

    for (genvar k = 0; k < 4; k++) begin : g_ch
        logic [WIDTH-1:0] r_mem [DEPTH];
        logic [PTR_W-1:0] r_wr;
        logic [PTR_W-1:0] r_rd;
        logic [PTR_W:0]   r_cnt;
        logic             w_push;
        logic             w_pop;

        assign w_push = in_valid && in_ready && (in_sel == 2'(k));
        assign w_pop  = (r_cnt != '0) && out_ready[k];
        assign w_full[k] = (r_cnt == c_full_cnt);

        assign out_valid[k]                     = (r_cnt != '0);
        assign out_data[k*WIDTH +: WIDTH]       = (r_cnt != '0) ? r_mem[r_rd] : '0;
        assign occ[k*(PTR_W+1) +: (PTR_W+1)]    = r_cnt;

        // Per-channel storage, pointers and occupancy; pointers wrap naturally
        // and full/empty are derived from the count only.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
                r_wr  <= '0;
                r_rd  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wr] <= in_data;
                    r_wr        <= r_wr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd <= r_rd + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_cnt <= r_cnt + (PTR_W+1)'(1);
                    2'b01:   r_cnt <= r_cnt - (PTR_W+1)'(1);
                    default: r_cnt <= r_cnt;
                endcase
            end
        end
    end

`ifdef DEMUX4_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    assign stall_cnt = r_stall_cnt;

    // Saturating count of cycles where the producer is held off.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (in_valid && !in_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux4_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux4_fifo
// Description : Directed self-checking bench for demux4_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux4_fifo;

    logic         clk;
    logic         rst;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   occ;
`ifdef DEMUX4_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int exp_stall = 0;

    demux4_fifo #(.WIDTH(32), .DEPTH(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .occ       (occ)
`ifdef DEMUX4_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        return out_data[k*32 +: 32];
    endfunction

    function automatic logic [1:0] occk(input int k);
        return occ[k*2 +: 2];
    endfunction

    task automatic push(input logic [1:0] sel, input logic [31:0] d);
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_stall = 0;
    endtask

    // Directed scenario sequence.
    initial begin
        rst = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0; out_ready = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_out_valid", 128'(out_valid), 128'h0);
        chk("reset_occ", 128'(occ), 128'h0);
        chk("reset_out_data", out_data, 128'h0);
        chk("reset_in_ready", 128'(in_ready), 128'h1);

        // Reset flush of a full ch2.
        push(2'd2, 32'hA5A5_0001);
        push(2'd2, 32'hA5A5_0002);
        in_sel = 2'd2;
        chk("flush_pre_occ2", 128'(occk(2)), 128'd2);
        chk("flush_pre_valid", 128'(out_valid), 128'b0100);
        chk("flush_pre_head", 128'(word(2)), 128'hA5A5_0001);
        chk("flush_pre_ready", 128'(in_ready), 128'h0);
        do_reset();
        chk("flush_out_valid", 128'(out_valid), 128'h0);
        chk("flush_occ", 128'(occ), 128'h0);
        chk("flush_out_data", out_data, 128'h0);
        chk("flush_in_ready", 128'(in_ready), 128'h1);

        // Routing to every channel.
        push(2'd0, 32'h11);
        chk("route_v0", 128'(out_valid), 128'b0001);
        chk("route_d0", 128'(word(0)), 128'h11);
        push(2'd1, 32'h22);
        chk("route_v1", 128'(out_valid), 128'b0011);
        chk("route_d1", 128'(word(1)), 128'h22);
        push(2'd2, 32'h33);
        chk("route_v2", 128'(out_valid), 128'b0111);
        chk("route_d2", 128'(word(2)), 128'h33);
        push(2'd3, 32'h44);
        chk("route_v3", 128'(out_valid), 128'b1111);
        chk("route_occ", 128'(occ), 128'b01_01_01_01);
        chk("route_data", out_data, {32'h44, 32'h33, 32'h22, 32'h11});
        do_reset();

        // Full backpressure on ch1.
        push(2'd1, 32'hDEAD_0000);
        push(2'd1, 32'hDEAD_0001);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 32'hDEAD_0002;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 128'(in_ready), 128'h0);
            tick();
            exp_stall++;
            chk("bp_occ1", 128'(occk(1)), 128'd2);
`ifdef DEMUX4_STALL_CNT_EN
            chk("bp_stall_cnt", 128'(stall_cnt), 128'(exp_stall));
`endif
        end
        in_valid = 1'b0;
        out_ready = 4'b0010;
        chk("bp_head0", 128'(word(1)), 128'hDEAD_0000);
        tick();
        chk("bp_head1", 128'(word(1)), 128'hDEAD_0001);
        tick();
        out_ready = 4'b0000;
        chk("bp_third_dropped_valid", 128'(out_valid), 128'h0);
        chk("bp_third_dropped_data", 128'(word(1)), 128'h0);

        // Simultaneous push/pop on ch0 with pointer wrap.
        push(2'd0, 32'h0FF);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h100 + 32'(i);
            out_ready = 4'b0001;
            chk("pp_head", 128'(word(0)), (i == 0) ? 128'h0FF : 128'(32'h100 + 32'(i) - 32'd1));
            chk("pp_in_ready", 128'(in_ready), 128'h1);
            tick();
            chk("pp_occ0", 128'(occk(0)), 128'd1);
        end
        in_valid = 1'b0;
        chk("pp_last", 128'(word(0)), 128'h105);
        tick();
        out_ready = 4'b0000;
        chk("pp_empty", 128'(out_valid), 128'h0);

        // Independent parallel drain of ch0 and ch3.
        push(2'd0, 32'hA0);
        push(2'd0, 32'hA1);
        push(2'd3, 32'hC0);
        push(2'd3, 32'hC1);
        out_ready = 4'b1001;
        chk("drain_h0a", 128'(word(0)), 128'hA0);
        chk("drain_h3a", 128'(word(3)), 128'hC0);
        tick();
        chk("drain_h0b", 128'(word(0)), 128'hA1);
        chk("drain_h3b", 128'(word(3)), 128'hC1);
        chk("drain_occ_mid", 128'(occ), 128'b01_00_00_01);
        tick();
        out_ready = 4'b0000;
        chk("drain_occ", 128'(occ), 128'h0);
        chk("drain_valid", 128'(out_valid), 128'h0);
        chk("drain_data", out_data, 128'h0);

        // Full channel with a same-cycle pop must still refuse the push.
        push(2'd2, 32'hE0);
        push(2'd2, 32'hE1);
        in_valid = 1'b1; in_sel = 2'd2; in_data = 32'hE2;
        out_ready = 4'b0100;
        chk("np_in_ready_full", 128'(in_ready), 128'h0);
        tick();
        exp_stall++;
        out_ready = 4'b0000;
        chk("np_occ_after_pop", 128'(occk(2)), 128'd1);
        chk("np_head_after_pop", 128'(word(2)), 128'hE1);
        chk("np_in_ready_free", 128'(in_ready), 128'h1);
        tick();
        in_valid = 1'b0;
        chk("np_occ_after_push", 128'(occk(2)), 128'd2);
        chk("np_head_kept", 128'(word(2)), 128'hE1);
`ifdef DEMUX4_STALL_CNT_EN
        chk("np_stall_cnt", 128'(stall_cnt), 128'(exp_stall));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
